seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan driver for the 4-digit common-anode 7-segment display.
- Generates the rotating 2-bit digit select consumed by the anode decoder, and produces the matching active-low anode, segment and decimal-point outputs.
- Inserts a blanking interval between digits to prevent ghosting, and captures each digit value once per slot so that mid-slot input changes cause no glitches.

---
 rtl/seg_scan_if.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// seg_scan_if : control/display bundle between a display client and seg_scan_ctrl
// Revision    : 1.0
// ============================================================================
interface seg_scan_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output en, digits, dp_in, blank_mask,
    input  sel, an, seg, dp, frame_tick
  );

  modport slave (
    input  en, digits, dp_in, blank_mask,
    output sel, an, seg, dp, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl : 4-digit common-anode 7-segment scan driver with inter-digit
//                 blanking and once-per-slot digit capture
// Revision      : 1.0
// ============================================================================
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  wire logic  clk,
  input  wire logic  rst,
  seg_scan_if.slave  bus
);

  localparam int              c_CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(REFRESH_DIV - 1);
  localparam logic [c_CW-1:0] c_CAP  = c_CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_ON    = 1'b1;

  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_sel;
  logic            r_tick;
  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [3:0]      r_nib;
  logic            r_dp_cap;
  logic            r_mask_cap;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic [3:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_dp;
  logic            w_wrap;
  logic            w_cap;

  assign w_wrap = (r_cnt == c_LAST);
  assign w_cap  = (r_cnt == c_CAP);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Slot counter and digit index; disabling abandons the slot and rewinds to slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sel  <= 2'd0;
      r_tick <= 1'b0;
    end else if (!bus.en) begin
      r_cnt  <= '0;
      r_sel  <= 2'd0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_sel  <= w_wrap ? r_sel + 2'd1 : r_sel;
      r_tick <= w_wrap && (r_sel == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nib      <= 4'd0;
      r_dp_cap   <= 1'b0;
      r_mask_cap <= 1'b0;
    end else if (bus.en && w_cap) begin
      r_nib      <= bus.digits[{r_sel, 2'b00} +: 4];
      r_dp_cap   <= bus.dp_in[r_sel];
      r_mask_cap <= bus.blank_mask[r_sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BLANK;
    else     r_state <= w_state_nxt;
  end

  // ON spans cnt BLANK_CYCLES..REFRESH_DIV-1, entered right after the capture cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (bus.en && w_cap)    w_state_nxt = S_ON;
      S_ON:    if (!bus.en || w_wrap)  w_state_nxt = S_BLANK;
      default:                         w_state_nxt = S_BLANK;
    endcase
  end

  always_comb begin
    w_an  = 4'b1111;
    w_seg = 7'b1111111;
    w_dp  = 1'b1;
    if (bus.en && (r_state == S_ON) && !r_mask_cap) begin
      w_an  = ~(4'b0001 << r_sel);
      w_seg = hex7(r_nib);
      w_dp  = ~r_dp_cap;
    end
  end

  // Registering all cathode/anode lines together keeps seg/dp edges aligned with an edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.sel        = r_sel;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_seg_scan_ctrl : self-checking bench for seg_scan_ctrl (8-cycle slots, 2 blank)
// Revision         : 1.0
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int R = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seg_scan_if bus ();

  seg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: k = cycles since scanning (re)started; slot = k/R, position = k%R
  int         k;
  logic [3:0] cap_nib;
  logic       cap_dp;
  logic       cap_mask;
  logic [6:0] hex_tab [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= 0;
      cap_nib  <= 4'd0;
      cap_dp   <= 1'b0;
      cap_mask <= 1'b0;
    end else begin
      if (bus.en && (k % R) == B - 1) begin
        cap_nib  <= bus.digits[4 * ((k / R) % 4) +: 4];
        cap_dp   <= bus.dp_in[(k / R) % 4];
        cap_mask <= bus.blank_mask[(k / R) % 4];
      end
      k <= bus.en ? k + 1 : 0;
    end
  end

  // Expected {sel, an, seg, dp, frame_tick}; outputs lag the lit phase by one register stage
  function automatic logic [14:0] model_out();
    logic [1:0] s;
    logic [3:0] a;
    logic [6:0] g;
    logic       d;
    logic       t;
    int         p;
    s = 2'((k / R) % 4);
    a = 4'b1111;
    g = 7'b1111111;
    d = 1'b1;
    t = (k > 0) && (k % (4 * R) == 0);
    if (k > 0) begin
      p = k - 1;
      if ((p % R) >= B && !cap_mask) begin
        a = ~(4'b0001 << ((p / R) % 4));
        g = hex_tab[cap_nib];
        d = ~cap_dp;
      end
    end
    return {s, a, g, d, t};
  endfunction

  function automatic logic [14:0] obs_now();
    return {bus.sel, bus.an, bus.seg, bus.dp, bus.frame_tick};
  endfunction

  task automatic test_reset();
    logic [14:0] e;
    total++;
    if (obs_now() !== {2'd0, 4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", obs_now(), {2'd0, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
    bus.digits = 16'h1A58;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL reset_run k=%0d got=%b want=%b", k, obs_now(), e);
      end
    end
    total++;
    if (bus.an !== 4'b1101) begin
      bad++;
      $display("FAIL pre_reset_an got=%b want=1101", bus.an);
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs_now() !== {2'd0, 4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", obs_now(), {2'd0, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_scan();
    logic [14:0] e;
    int ticks = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL basic k=%0d got=%b want=%b", k, obs_now(), e);
      end
      total++;
      if ($countones(~bus.an) > 1) begin
        bad++;
        $display("FAIL basic_onehot k=%0d an=%b want at most one low", k, bus.an);
      end
      if (bus.frame_tick === 1'b1) ticks++;
    end
    total++;
    if (ticks != 2) begin
      bad++;
      $display("FAIL basic_tick_count got=%0d want=2", ticks);
    end
  endtask

  task automatic test_capture();
    logic [14:0] e;
    int n;
    n = 0;
    while ((k % (4 * R)) != 5 && n < 40) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL capture_pre k=%0d got=%b want=%b", k, obs_now(), e);
      end
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL capture_sync timeout got=%0d want<40", n);
    end
    bus.digits[3:0] = 4'h0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL capture k=%0d got=%b want=%b", k, obs_now(), e);
      end
      if (i < 3) begin
        total++;
        if (bus.seg !== 7'b0000000) begin
          bad++;
          $display("FAIL capture_hold k=%0d seg=%b want=0000000", k, bus.seg);
        end
      end
      if ((k % (4 * R)) == 4 && i > 8) begin
        total++;
        if (bus.seg !== 7'b1000000 || bus.an !== 4'b1110) begin
          bad++;
          $display("FAIL capture_next an=%b seg=%b want an=1110 seg=1000000", bus.an, bus.seg);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    logic [14:0] e;
    int last_tick = -1;
    int cyc = 0;
    bus.blank_mask = 4'b0100;
    bus.dp_in = 4'b0001;
    bus.digits = 16'h1A58;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      cyc++;
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL blank_dp k=%0d got=%b want=%b", k, obs_now(), e);
      end
      total++;
      if (bus.an === 4'b1011 || (bus.an === 4'b1110 && bus.dp !== 1'b0)) begin
        bad++;
        $display("FAIL blank_dp_rule k=%0d an=%b dp=%b want no an=1011, dp=0 with an=1110", k, bus.an, bus.dp);
      end
      if (bus.frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          total++;
          if (cyc - last_tick != 4 * R) begin
            bad++;
            $display("FAIL frame_period got=%0d want=%0d", cyc - last_tick, 4 * R);
          end
        end
        last_tick = cyc;
      end
    end
    bus.blank_mask = 4'b0000;
    bus.dp_in = 4'b0000;
  endtask

  task automatic test_enable_toggle();
    logic [14:0] e;
    int n;
    int lit;
    n = 0;
    while (!(((k / R) % 4) == 1 && (k % R) == 4) && n < 40) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL enable_pre k=%0d got=%b want=%b", k, obs_now(), e);
      end
      n++;
    end
    total++;
    if (n >= 40 || bus.an !== 4'b1101) begin
      bad++;
      $display("FAIL enable_sync an=%b n=%0d want an=1101 n<40", bus.an, n);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.an !== 4'b1111 || bus.sel !== 2'd0 || bus.frame_tick !== 1'b0) begin
        bad++;
        $display("FAIL enable_off an=%b sel=%0d tick=%b want an=1111 sel=0 tick=0", bus.an, bus.sel, bus.frame_tick);
      end
    end
    bus.en = 1'b1;
    lit = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL enable_on k=%0d got=%b want=%b", k, obs_now(), e);
      end
      if (bus.an === 4'b1110) lit++;
    end
    total++;
    if (lit != R - B) begin
      bad++;
      $display("FAIL enable_lit_count got=%0d want=%0d", lit, R - B);
    end
  endtask

  task automatic test_random();
    logic [14:0] e;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      e = model_out();
      total++;
      if (obs_now() !== e) begin
        bad++;
        $display("FAIL random k=%0d got=%b want=%b", k, obs_now(), e);
      end
      total++;
      if ($countones(~bus.an) > 1) begin
        bad++;
        $display("FAIL random_onehot k=%0d an=%b want at most one low", k, bus.an);
      end
      if ($urandom_range(7, 0) == 0) bus.digits = 16'($urandom);
      if ($urandom_range(15, 0) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(15, 0) == 0) bus.blank_mask = 4'($urandom);
      if (bus.en) begin
        if ($urandom_range(59, 0) == 0) bus.en = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        bus.en = 1'b1;
      end
    end
  endtask

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
    hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
    hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
    hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.digits     = 16'h0000;
    bus.dp_in      = 4'b0000;
    bus.blank_mask = 4'b0000;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_scan();
    test_capture();
    test_blank_dp();
    test_enable_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
